// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding and character constants for the line echo framer
package uart_pkg;

  typedef enum logic [2:0] {
    ST_COLLECT,
    ST_PROMPT,
    ST_BODY,
    ST_CR,
    ST_LF
  } framer_state_t;

  localparam logic [7:0] CHR_CR = 8'h0D;
  localparam logic [7:0] CHR_LF = 8'h0A;
  localparam logic [7:0] CHR_BS = 8'h08;

  // "echo> " as a byte array, index 0 is sent first
  localparam logic [0:5][7:0] PROMPT_BYTES = {8'h65, 8'h63, 8'h68, 8'h6F, 8'h3E, 8'h20};

endpackage

// File: rtl/line_echo_framer_if.sv
// rtl/line_echo_framer_if.sv - receive and transmit byte handshakes of the line echo framer
interface line_echo_framer_if;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       rx_data_ready;
  logic [7:0] tx_data;
  logic       tx_data_valid;
  logic       tx_data_ready;

  modport master (
    output rx_data, rx_data_valid, tx_data_ready,
    input  rx_data_ready, tx_data, tx_data_valid
  );

  modport slave (
    input  rx_data, rx_data_valid, tx_data_ready,
    output rx_data_ready, tx_data, tx_data_valid
  );
endinterface

// File: rtl/line_buf_ram.sv
// rtl/line_buf_ram.sv - line buffer: one synchronous write port, one registered read port
module line_buf_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/line_echo_framer.sv
// rtl/line_echo_framer.sv - collects a line of received bytes and echoes it back behind a prompt
module line_echo_framer
  import uart_pkg::*;
#(
  parameter int BUF_DEPTH  = 64,
  parameter int PROMPT_LEN = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  line_echo_framer_if.slave   bus,
  output logic                overflow,
  output logic                busy
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int PW = $clog2(PROMPT_LEN);
  localparam logic [AW:0]   CNT_FULL  = (AW+1)'(BUF_DEPTH);
  localparam logic [AW:0]   CNT_ONE   = 1;
  localparam logic [AW-1:0] IDX_ONE   = 1;
  localparam logic [PW-1:0] PIDX_ONE  = 1;
  localparam logic [PW-1:0] PIDX_LAST = PW'(PROMPT_LEN - 1);

  framer_state_t state, state_nxt;
  logic [AW:0]   count, count_nxt;
  logic [PW-1:0] pidx, pidx_nxt;
  logic [AW-1:0] rd_idx, rd_idx_nxt;
  logic          rd_pend, rd_pend_nxt;
  logic          ovf_nxt;

  logic          wr_en, rd_en;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic [7:0]    tx_data_c;
  logic          tx_valid_c;
  logic          rx_fire;

  assign rx_fire           = bus.rx_data_valid && bus.rx_data_ready;
  assign bus.rx_data_ready = (state == ST_COLLECT);
  assign bus.tx_data       = tx_data_c;
  assign bus.tx_data_valid = tx_valid_c;
  assign busy              = (state != ST_COLLECT);

  line_buf_ram #(.DEPTH(BUF_DEPTH), .AW(AW)) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (count[AW-1:0]),
    .wr_data (bus.rx_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_COLLECT;
      count    <= '0;
      pidx     <= '0;
      rd_idx   <= '0;
      rd_pend  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      pidx     <= pidx_nxt;
      rd_idx   <= rd_idx_nxt;
      rd_pend  <= rd_pend_nxt;
      overflow <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    pidx_nxt    = pidx;
    rd_idx_nxt  = rd_idx;
    rd_pend_nxt = rd_pend;
    ovf_nxt     = overflow;
    wr_en       = 1'b0;
    rd_en       = 1'b0;
    rd_addr     = rd_idx;
    tx_data_c   = 8'h00;
    tx_valid_c  = 1'b0;
    case (state)
      ST_COLLECT: begin
        if (rx_fire) begin
          if (bus.rx_data == CHR_CR) begin
            state_nxt = ST_PROMPT;
            pidx_nxt  = '0;
          end else if (bus.rx_data == CHR_LF) begin
            state_nxt = ST_COLLECT;
          end else if (bus.rx_data == CHR_BS) begin
            if (count != '0) count_nxt = count - CNT_ONE;
          end else if (count == CNT_FULL) begin
            ovf_nxt = 1'b1;
          end else begin
            wr_en     = 1'b1;
            count_nxt = count + CNT_ONE;
          end
        end
      end
      ST_PROMPT: begin
        tx_data_c  = PROMPT_BYTES[pidx];
        tx_valid_c = 1'b1;
        if (bus.tx_data_ready) begin
          if (pidx == PIDX_LAST) begin
            if (count == '0) begin
              state_nxt = ST_CR;
            end else begin
              // prefetch byte 0 so the body starts without a bubble
              state_nxt   = ST_BODY;
              rd_en       = 1'b1;
              rd_addr     = '0;
              rd_idx_nxt  = '0;
              rd_pend_nxt = 1'b1;
            end
          end else begin
            pidx_nxt = pidx + PIDX_ONE;
          end
        end
      end
      ST_BODY: begin
        tx_data_c  = rd_data;
        tx_valid_c = rd_pend;
        if (rd_pend && bus.tx_data_ready) begin
          if (({1'b0, rd_idx} + CNT_ONE) == count) begin
            state_nxt   = ST_CR;
            rd_pend_nxt = 1'b0;
          end else begin
            rd_en      = 1'b1;
            rd_addr    = rd_idx + IDX_ONE;
            rd_idx_nxt = rd_idx + IDX_ONE;
          end
        end
      end
      ST_CR: begin
        tx_data_c  = CHR_CR;
        tx_valid_c = 1'b1;
        if (bus.tx_data_ready) state_nxt = ST_LF;
      end
      ST_LF: begin
        tx_data_c  = CHR_LF;
        tx_valid_c = 1'b1;
        if (bus.tx_data_ready) begin
          state_nxt = ST_COLLECT;
          count_nxt = '0;
          ovf_nxt   = 1'b0;
        end
      end
      default: state_nxt = ST_COLLECT;
    endcase
  end

endmodule

// File: doc/line_echo_framer.md
LINE_ECHO_FRAMER -- requirements
Module: line_echo_framer

Interface
REQ-001 SHALL have parameter BUF_DEPTH, default 64, meaning line buffer capacity in bytes (power of two, 4..256).
REQ-002 SHALL have parameter PROMPT_LEN, default 6, meaning byte count of the fixed prompt "echo> ".
REQ-003 SHALL have port clk, input, 1, system clock.
REQ-004 SHALL have port rst_n, input, 1, reset (asynchronous, active-low).
REQ-005 SHALL have port rx_data, input, 8, received byte from the UART receiver.
REQ-006 SHALL have port rx_data_valid, input, 1, rx_data qualifier; a byte is accepted when rx_data_valid and rx_data_ready are both high.
REQ-007 SHALL have port rx_data_ready, output, 1, framer can accept a byte.
REQ-008 SHALL have port tx_data, output, 8, byte to the UART transmitter.
REQ-009 SHALL have port tx_data_valid, output, 1, tx_data qualifier.
REQ-010 SHALL have port tx_data_ready, input, 1, transmitter accepts; a transfer occurs when tx_data_valid and tx_data_ready are both high.
REQ-011 SHALL have port overflow, output, 1, sticky flag: the current line lost bytes.
REQ-012 SHALL have port busy, output, 1, high in any state other than COLLECT.

Function
REQ-013 SHALL implement states COLLECT, PROMPT, BODY, CR, LF.
REQ-014 In COLLECT, rx_data_ready SHALL be 1; in all other states it SHALL be 0.
REQ-015 An accepted byte in COLLECT SHALL be handled as follows:
- 0x0D: ends the line; the byte is not stored; next state PROMPT, prompt index 0.
- 0x0A: ignored.
- 0x08: decrements the line count if it is >0, else no effect.
- Any other byte: written at the line count, and the count increments.
REQ-016 When the line count equals BUF_DEPTH, further printable bytes SHALL be dropped and overflow set; 0x08 and 0x0D still act normally.
REQ-017 PROMPT SHALL emit the prompt bytes 0x65 0x63 0x68 0x6F 0x3E 0x20 in order, then go to BODY.
REQ-018 BODY SHALL emit the stored bytes from index 0 to count-1, then go to CR; with count 0, BODY SHALL go to CR without emitting any byte.
REQ-019 CR SHALL emit 0x0D and LF SHALL emit 0x0A; after the LF transfer, the state SHALL be COLLECT, count 0 and overflow 0.
REQ-020 tx_data_valid SHALL be high in PROMPT, CR and LF, and in BODY when a byte is pending.
REQ-021 Once tx_data_valid is high, tx_data SHALL be stable until the transfer, and tx_data_valid SHALL not drop before the transfer.
REQ-022 Each transfer SHALL advance to the next byte; the next byte SHALL be presented with tx_data_valid high in the following cycle, giving at most one bubble cycle per byte (buffer read latency).
REQ-023 tx_data_ready held high SHALL give one transfer every one or two cycles; the framer SHALL not depend on tx_data_ready being high before tx_data_valid.
REQ-024 The line count SHALL be log2(BUF_DEPTH)+1 bits wide and SHALL never wrap; read and write indices SHALL be log2(BUF_DEPTH) bits wide.
REQ-025 A write and a read of the buffer in the same cycle cannot occur because the states are exclusive; the buffer SHALL nevertheless have one write port and one read port.

Reset
REQ-026 While rst_n is low, the block SHALL be in COLLECT with line count 0, all indices 0, tx_data 0x00, tx_data_valid 0, overflow 0, busy 0 and rx_data_ready 1.
REQ-027 Reset asserted mid-transmission SHALL abort the line immediately; buffer contents need no reset.

Structure
REQ-028 Shared package uart_pkg SHALL hold the state enum, constants CHR_CR, CHR_LF and CHR_BS, and the prompt byte array.
REQ-029 The buffer SHALL be sub-module line_buf_ram: synchronous write, registered one-cycle read, no reset.

Verification
REQ-030 Receive "ab",0x0D with tx_data_ready held 1 -> transmit 65 63 68 6F 3E 20 61 62 0D 0A; rx_data_ready is 0 until after 0x0A.
REQ-031 Receive 0x0D alone -> transmit 65 63 68 6F 3E 20 0D 0A.
REQ-032 Receive "abc",0x08,"d",0x0D -> body 61 62 64.
REQ-033 Receive 70 bytes of 0x41, then 0x0D, with BUF_DEPTH=64 -> overflow=1, body is exactly 64 bytes of 0x41, overflow=0 after LF.
REQ-034 Randomly toggle tx_data_ready during transmission -> byte order unchanged, tx_data stable while valid is high and ready is low, no byte duplicated.
REQ-035 Assert rst_n low after the third tx transfer -> tx_data_valid=0 and rx_data_ready=1; the next line echoes correctly.
